// File: rtl/uart_rx_buffer.sv
// Memory-mapped UART receiver: 2-FF synchronised RX line, 8N1 deframer, byte FIFO, DATA/STATUS read mux.
// Define UART_RX_PARITY_EN to receive an even-parity bit between bit 7 and the stop bit.
`timescale 1ns/1ps
module uart_rx_buffer #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 8,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_line,
    input  logic                  rd_en,
    input  logic                  addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rx_irq,
    output logic                  busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          state_q;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            stop_wait_q;
    logic            busy_q;
    logic            par_bad;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            overrun_q, frame_err_q, parity_err_w;
    logic            overrun_d, frame_err_d;

    logic stop_sample, push_req, frame_set, pop, full, push_ok, overrun_set, sticky_clr;
    logic [DATA_WIDTH-1:0] status_w, head_w;

    assign rx_s = sync_q[1];

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, parity_err_q, parity_err_d, parity_set;
    assign par_bad      = par_bad_q;
    assign parity_err_w = parity_err_q;
    assign parity_set   = (state_q == S_PARITY) && (cnt_q == CNT_LAST) && (^{shift_q, rx_s});
`else
    assign par_bad      = 1'b0;
    assign parity_err_w = 1'b0;
`endif

    // Receive FSM; the byte is complete in shift_q from the bit-7 sample onward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b11;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            stop_wait_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
`endif
        end else begin
            sync_q <= {sync_q[0], rx_line};
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_bad_q <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        if (!rx_s) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_STOP;
`ifdef UART_RX_PARITY_EN
                        par_bad_q <= ^{shift_q, rx_s};
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (stop_wait_q) begin
                        if (rx_s) begin
                            stop_wait_q <= 1'b0;
                            state_q     <= S_IDLE;
                            busy_q      <= 1'b0;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            stop_wait_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign stop_sample = (state_q == S_STOP) && !stop_wait_q && (cnt_q == CNT_LAST);
    assign push_req    = stop_sample && rx_s && !par_bad;
    assign frame_set   = stop_sample && !rx_s;
    assign full        = (count_q == DEPTH_C);
    assign pop         = rd_en && !addr && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok     = push_req && (!full || pop);
    assign overrun_set = push_req && full && !pop;
    assign sticky_clr  = rd_en && addr;

    always_comb begin
        count_d     = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        overrun_d   = overrun_set ? 1'b1 : (sticky_clr ? 1'b0 : overrun_q);
        frame_err_d = frame_set ? 1'b1 : (sticky_clr ? 1'b0 : frame_err_q);
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_set ? 1'b1 : (sticky_clr ? 1'b0 : parity_err_q);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    always_comb begin
        status_w            = '0;
        status_w[0]         = (count_q != '0);
        status_w[1]         = full;
        status_w[2]         = overrun_q;
        status_w[3]         = frame_err_q;
        status_w[4]         = parity_err_w;
        status_w[8 +: AW+1] = count_q;
        head_w              = '0;
        if (count_q != '0) head_w[7:0] = mem_q[rd_ptr_q];
        rd_data = addr ? status_w : head_w;
    end

    assign rx_irq = (count_q != '0);
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: serial frames driven on rx_line, registers read through the DATA/STATUS mux.
`timescale 1ns/1ps
module tb_uart_rx_buffer;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_EDGE = 170;
`else
  localparam int STOP_EDGE = 154;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_line = 1'b1;
  logic        rd_en = 1'b0;
  logic        addr = 1'b0;
  logic [31:0] rd_data;
  logic        rx_irq;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic [31:0] val;

  uart_rx_buffer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rx_line(rx_line), .rd_en(rd_en), .addr(addr),
    .rd_data(rd_data), .rx_irq(rx_irq), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete, observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; each bit is held for CPB clocks.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx_line = par;
    repeat (CPB) @(negedge clk);
`endif
    rx_line = stop;
    repeat (CPB) @(negedge clk);
    rx_line = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, ^d, 1'b1);
    idle(2);
  endtask

  task automatic do_read(input logic a, output logic [31:0] v);
    rd_en = 1'b1;
    addr  = a;
    #1 v = rd_data;
    @(negedge clk);
    rd_en = 1'b0;
    addr  = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_data", rd_data, 32'h0);
    check("rst_irq", {31'h0, rx_irq}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    idle(4);
    do_read(1'b1, val); check("rst_status", val, 32'h0);

    // asynchronous reset in the middle of a frame
    send_byte(8'h5A);
    check("pre_rst_irq", {31'h0, rx_irq}, 32'h1);
    rx_line = 1'b0;
    repeat (40) @(negedge clk);
    check("midframe_busy", {31'h0, busy}, 32'h1);
    #3 rst = 1'b1; rx_line = 1'b1;
    #1;
    check("async_rst_data", rd_data, 32'h0);
    check("async_rst_irq", {31'h0, rx_irq}, 32'h0);
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(48);
    check("post_rst_irq", {31'h0, rx_irq}, 32'h0);
    do_read(1'b1, val); check("post_rst_status", val, 32'h0);

    // single byte
    send_byte(8'hA5);
    check("a5_irq", {31'h0, rx_irq}, 32'h1);
    do_read(1'b1, val); check("a5_status", val, 32'h0000_0101);
    do_read(1'b0, val); check("a5_data", val, 32'h0000_00A5);
    do_read(1'b1, val); check("a5_status_after", val, 32'h0);
    do_read(1'b0, val); check("empty_data", val, 32'h0);

    // overrun: nine bytes into eight entries
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    do_read(1'b1, val); check("ovr_status", val, 32'h0000_0807);
    do_read(1'b1, val); check("ovr_cleared", val, 32'h0000_0803);
    for (int i = 1; i <= 8; i++) begin
      do_read(1'b0, val); check($sformatf("ovr_data%0d", i), val, 32'(i));
    end
    do_read(1'b1, val); check("ovr_drained", val, 32'h0);

    // framing error, then recovery
    send_frame(8'h3C, ^8'h3C, 1'b0);
    idle(32);
    check("ferr_irq", {31'h0, rx_irq}, 32'h0);
    check("ferr_busy", {31'h0, busy}, 32'h0);
    do_read(1'b1, val); check("ferr_status", val, 32'h0000_0008);
    do_read(1'b1, val); check("ferr_cleared", val, 32'h0);
    send_byte(8'h55);
    do_read(1'b1, val); check("rec_status", val, 32'h0000_0101);
    do_read(1'b0, val); check("rec_data", val, 32'h0000_0055);

    // quarter-bit glitch
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    rx_line = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy", {31'h0, busy}, 32'h1);
    idle(20);
    check("glitch_idle", {31'h0, busy}, 32'h0);
    check("glitch_irq", {31'h0, rx_irq}, 32'h0);

    // full FIFO, push coinciding with a pop
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    do_read(1'b1, val); check("full_status", val, 32'h0000_0803);
    fork
      send_frame(8'h18, ^8'h18, 1'b1);
      begin
        repeat (STOP_EDGE) @(negedge clk);
        do_read(1'b0, val); check("coinc_head", val, 32'h0000_0010);
      end
    join
    idle(2);
    do_read(1'b1, val); check("coinc_status", val, 32'h0000_0803);
    for (int i = 1; i <= 8; i++) begin
      do_read(1'b0, val); check($sformatf("coinc_data%0d", i), val, 32'h10 + 32'(i));
    end
    do_read(1'b1, val); check("coinc_drained", val, 32'h0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2);
    do_read(1'b1, val); check("par_ok_status", val, 32'h0000_0101);
    do_read(1'b0, val); check("par_ok_data", val, 32'h0000_0007);
    send_frame(8'h07, 1'b0, 1'b1);
    idle(2);
    check("par_bad_irq", {31'h0, rx_irq}, 32'h0);
    do_read(1'b1, val); check("par_bad_status", val, 32'h0000_0010);
    send_frame(8'h07, 1'b0, 1'b0);
    idle(32);
    do_read(1'b1, val); check("par_frame_status", val, 32'h0000_0018);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
